// File: rtl/ram_burst_arbiter_if.sv
// Requester and RAM-pin bundle for the activation/weight RAM burst arbiter.
interface ram_burst_arbiter_if #(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 16
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic              req0_write;
    logic              req1_write;
    logic [ADDR_W-1:0] req0_base;
    logic [ADDR_W-1:0] req1_base;
    logic [LEN_W-1:0]  req0_len;
    logic [LEN_W-1:0]  req1_len;
    logic [7:0]        req0_wdata;
    logic [7:0]        req1_wdata;
    logic [1:0]        wdata_valid;
    logic [1:0]        wdata_ready;
    logic [7:0]        rdata;
    logic [1:0]        rdata_valid;
    logic [1:0]        done;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_read;
    logic              ram_write;
    logic [7:0]        ram_dataout;

    modport slave (
        input  req_valid, req0_write, req1_write, req0_base, req1_base,
               req0_len, req1_len, req0_wdata, req1_wdata, wdata_valid, ram_dataout,
        output req_ready, wdata_ready, rdata, rdata_valid, done,
               ram_addr, ram_wdata, ram_read, ram_write
    );

    modport master (
        output req_valid, req0_write, req1_write, req0_base, req1_base,
               req0_len, req1_len, req0_wdata, req1_wdata, wdata_valid, ram_dataout,
        input  req_ready, wdata_ready, rdata, rdata_valid, done,
               ram_addr, ram_wdata, ram_read, ram_write
    );
endinterface

// File: rtl/ram_burst_arbiter.sv
// Round-robin burst sequencer for the shared 32K x 8 RAM (IO loader = 0, DCNN core = 1).
// Optional RAM clear controller enabled by defining RAM_CLEAR_EN.
module ram_burst_arbiter #(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic clk,
    input  logic RST,
    ram_burst_arbiter_if.slave bus
`ifdef RAM_CLEAR_EN
    ,
    input  logic clr_req,
    output logic clr_busy,
    output logic ram_clr
`endif
);
    // state | meaning
    // IDLE  | arbitrate, accept one command
    // READ  | one ram_read per cycle until the burst is issued
    // WRITE | one ram_write per valid data beat
    // DONE  | one-cycle done pulse, update round-robin pointer
    // CLEAR | one-cycle RAM clear (RAM_CLEAR_EN only)
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, CLEAR} state_t;

    state_t            state, next_state;
    logic              g, rr_last;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              rd_pend;

    logic              gnt_id, grant, beat;
    logic [ADDR_W-1:0] sel_base;
    logic [LEN_W-1:0]  sel_len;
    logic              sel_write;
    logic [1:0]        req_ready_c, wdata_ready_c, done_c;
    logic              ram_read_c, ram_write_c, clr_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [7:0]        ram_wdata_c;

    // Under contention the requester that was not served last wins
    assign gnt_id    = (bus.req_valid == 2'b11) ? ~rr_last : bus.req_valid[1];
    assign sel_base  = gnt_id ? bus.req1_base  : bus.req0_base;
    assign sel_len   = gnt_id ? bus.req1_len   : bus.req0_len;
    assign sel_write = gnt_id ? bus.req1_write : bus.req0_write;

    always_comb begin
        next_state    = state;
        grant         = 1'b0;
        beat          = 1'b0;
        req_ready_c   = '0;
        wdata_ready_c = '0;
        done_c        = '0;
        ram_read_c    = 1'b0;
        ram_write_c   = 1'b0;
        ram_addr_c    = '0;
        ram_wdata_c   = '0;
        clr_c         = 1'b0;
        case (state)
            IDLE: begin
`ifdef RAM_CLEAR_EN
                if (clr_req) next_state = CLEAR;
                else
`endif
                if (bus.req_valid != 2'b00) begin
                    grant               = 1'b1;
                    req_ready_c[gnt_id] = 1'b1;
                    if (sel_len == '0)  next_state = DONE;
                    else if (sel_write) next_state = WRITE;
                    else                next_state = READ;
                end
            end
            READ: begin
                ram_read_c = 1'b1;
                ram_addr_c = addr;
                beat       = 1'b1;
                if (remaining == LEN_W'(1)) next_state = DONE;
            end
            WRITE: begin
                wdata_ready_c[g] = 1'b1;
                ram_write_c      = bus.wdata_valid[g];
                ram_addr_c       = addr;
                ram_wdata_c      = g ? bus.req1_wdata : bus.req0_wdata;
                beat             = ram_write_c;
                if (beat && remaining == LEN_W'(1)) next_state = DONE;
            end
            DONE: begin
                done_c[g]  = 1'b1;
                next_state = IDLE;
            end
`ifdef RAM_CLEAR_EN
            CLEAR: begin
                clr_c      = 1'b1;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            state     <= IDLE;
            g         <= 1'b0;
            rr_last   <= 1'b1;
            addr      <= '0;
            remaining <= '0;
            rd_pend   <= 1'b0;
        end else begin
            state   <= next_state;
            rd_pend <= ram_read_c;
            if (grant) begin
                g         <= gnt_id;
                addr      <= sel_base;
                remaining <= sel_len;
            end else if (beat) begin
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            if (state == DONE) rr_last <= g;
        end
    end

    // Outputs are forced low while reset is asserted so a dropped burst cannot leak a strobe
    assign bus.req_ready   = RST ? req_ready_c   : 2'b00;
    assign bus.wdata_ready = RST ? wdata_ready_c : 2'b00;
    assign bus.done        = RST ? done_c        : 2'b00;
    assign bus.rdata_valid = (RST && rd_pend) ? (g ? 2'b10 : 2'b01) : 2'b00;
    assign bus.ram_read    = RST & ram_read_c;
    assign bus.ram_write   = RST & ram_write_c;
    assign bus.ram_addr    = RST ? ram_addr_c  : '0;
    assign bus.ram_wdata   = RST ? ram_wdata_c : '0;
    assign bus.rdata       = bus.ram_dataout;

`ifdef RAM_CLEAR_EN
    assign ram_clr  = RST & clr_c;
    assign clr_busy = RST & clr_c;
`else
    logic unused_clr;
    assign unused_clr = clr_c;
`endif
endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Directed bench for ram_burst_arbiter with a behavioural 32K x 8 registered-read RAM.
module tb_ram_burst_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ram_burst_arbiter_if #(.LEN_W(8), .ADDR_W(16)) bus ();

`ifdef RAM_CLEAR_EN
    logic clr_req, clr_busy, ram_clr;
    ram_burst_arbiter u_dut (.clk(clk), .RST(rst), .bus(bus),
                             .clr_req(clr_req), .clr_busy(clr_busy), .ram_clr(ram_clr));
`else
    ram_burst_arbiter u_dut (.clk(clk), .RST(rst), .bus(bus));
`endif

    logic [7:0] mem [0:32767];

    always @(posedge clk) begin
`ifdef RAM_CLEAR_EN
        if (ram_clr) for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
`endif
        if (bus.ram_write) mem[bus.ram_addr[14:0]] <= bus.ram_wdata;
        if (bus.ram_read)  bus.ram_dataout <= mem[bus.ram_addr[14:0]];
    end

    typedef struct {
        logic        id;
        logic        wr;
        logic [15:0] base;
        logic [7:0]  len;
        int          stall_at;
        int          stall_n;
        logic [7:0]  d0;
        logic [7:0]  inc;
        int          exp_done;
    } burst_t;

    burst_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.done,
                    bus.ram_read, bus.ram_write, bus.ram_addr, bus.ram_wdata});
    endfunction

    task automatic clear_inputs();
        bus.req_valid   = 2'b00;
        bus.req0_write  = 1'b0;
        bus.req1_write  = 1'b0;
        bus.req0_base   = 16'h0;
        bus.req1_base   = 16'h0;
        bus.req0_len    = 8'h0;
        bus.req1_len    = 8'h0;
        bus.req0_wdata  = 8'h0;
        bus.req1_wdata  = 8'h0;
        bus.wdata_valid = 2'b00;
`ifdef RAM_CLEAR_EN
        clr_req = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("reset outputs", all_outs(), 64'h0);
    endtask

    task automatic run_burst(input burst_t b, input string name);
        int         issued = 0;
        int         got    = 0;
        int         stalls = 0;
        logic       prev_read = 1'b0;
        logic       done_seen = 1'b0;
        logic       stall_now, exp_r, exp_w;
        logic [1:0] oh;
        logic [15:0] ea;
        logic [7:0]  ed;
        oh = b.id ? 2'b10 : 2'b01;
        @(negedge clk);
        bus.req_valid = oh;
        if (b.id) begin
            bus.req1_write = b.wr; bus.req1_base = b.base; bus.req1_len = b.len;
        end else begin
            bus.req0_write = b.wr; bus.req0_base = b.base; bus.req0_len = b.len;
        end
        #1 chk({name, " req_ready"}, 64'(bus.req_ready), 64'(oh));
        for (int cyc = 1; cyc <= b.exp_done + 4 && !done_seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.req_valid = 2'b00;
                bus.req0_base = ~b.base; bus.req1_base = ~b.base;
                bus.req0_len  = 8'hFF;   bus.req1_len  = 8'hFF;
            end
            stall_now = b.wr && issued < int'(b.len) && issued == b.stall_at && stalls < b.stall_n;
            exp_r = !b.wr && issued < int'(b.len);
            exp_w = b.wr && issued < int'(b.len) && !stall_now;
            ea = b.base + 16'(issued);
            ed = b.d0 + 8'(issued);
            bus.wdata_valid = exp_w ? oh : 2'b00;
            bus.req0_wdata  = b.id ? 8'hEE : ed;
            bus.req1_wdata  = b.id ? ed : 8'hEE;
            #1;
            chk({name, " ram_read"},  64'(bus.ram_read),  64'(exp_r));
            chk({name, " ram_write"}, 64'(bus.ram_write), 64'(exp_w));
            if (exp_r || exp_w) chk({name, " ram_addr"}, 64'(bus.ram_addr), 64'(ea));
            if (exp_w) chk({name, " ram_wdata"}, 64'(bus.ram_wdata), 64'(ed));
            chk({name, " wdata_ready"}, 64'(bus.wdata_ready),
                64'((b.wr && issued < int'(b.len)) ? oh : 2'b00));
            chk({name, " rdata_valid"}, 64'(bus.rdata_valid), 64'(prev_read ? oh : 2'b00));
            if (prev_read) begin
                chk({name, " rdata"}, 64'(bus.rdata), 64'(b.d0 + 8'(got) * b.inc));
                got++;
            end
            chk({name, " done"}, 64'(bus.done), 64'((issued == int'(b.len)) ? oh : 2'b00));
            if (issued == int'(b.len)) begin
                done_seen = 1'b1;
                chk({name, " done cycle"}, 64'(cyc), 64'(b.exp_done));
            end
            prev_read = exp_r;
            if (exp_r || exp_w) issued++;
            if (stall_now) stalls++;
        end
        if (!done_seen) chk({name, " done timeout"}, 64'(0), 64'(1));
        bus.wdata_valid = 2'b00;
    endtask

    initial begin
        int grants;
        rst = 1'b0;
        clear_inputs();
        bus.ram_dataout = 8'h00;

        //          id    wr    base      len   st  sn  d0     inc   done
        tbl[0] = '{1'b0, 1'b1, 16'h0010, 8'd4, -1, 0, 8'hA1, 8'd1, 5};
        tbl[1] = '{1'b1, 1'b0, 16'h0010, 8'd4, -1, 0, 8'hA1, 8'd1, 5};
        tbl[2] = '{1'b0, 1'b1, 16'h0100, 8'd3,  1, 2, 8'h30, 8'd1, 6};
        tbl[3] = '{1'b1, 1'b0, 16'h0100, 8'd3, -1, 0, 8'h30, 8'd1, 4};
        tbl[4] = '{1'b0, 1'b1, 16'hFFFE, 8'd3, -1, 0, 8'h50, 8'd1, 4};
        tbl[5] = '{1'b1, 1'b0, 16'hFFFE, 8'd3, -1, 0, 8'h50, 8'd1, 4};
        tbl[6] = '{1'b0, 1'b0, 16'h2000, 8'd0, -1, 0, 8'h00, 8'd1, 1};

        do_reset();
        for (int i = 0; i < 7; i++) run_burst(tbl[i], $sformatf("vec%0d", i));

        // Contention: alternate 0,1,0,1,... starting with requester 0 after reset
        do_reset();
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req0_len  = 8'd0;
        bus.req1_len  = 8'd0;
        grants = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                chk($sformatf("rr grant%0d", grants), 64'(bus.req_ready),
                    64'((grants % 2 == 0) ? 2'b01 : 2'b10));
                grants++;
            end
            @(negedge clk);
        end
        if (grants < 6) chk("rr timeout", 64'(grants), 64'(6));
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);

        // Reset asserted on beat 2 of a 5-byte read
        do_reset();
        @(negedge clk);
        bus.req_valid = 2'b01; bus.req0_write = 1'b0; bus.req0_base = 16'h0010; bus.req0_len = 8'd5;
        #1 chk("rstmid ready", 64'(bus.req_ready), 64'(2'b01));
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1 chk("rstmid beat2 read", 64'(bus.ram_read), 64'(1));
        chk("rstmid beat2 addr", 64'(bus.ram_addr), 64'(16'h0011));
        rst = 1'b0;
        #1 chk("rstmid during rst", all_outs(), 64'h0);
        @(negedge clk);
        chk("rstmid after rst", all_outs(), 64'h0);
        rst = 1'b1;
        #1 chk("rstmid idle", all_outs(), 64'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid no done%0d", c), 64'(bus.done), 64'(0));
        end
        run_burst(tbl[1], "post rst read");

`ifdef RAM_CLEAR_EN
        @(negedge clk);
        clr_req = 1'b1;
        bus.req_valid = 2'b01; bus.req0_write = 1'b0; bus.req0_base = 16'h0010; bus.req0_len = 8'd4;
        #1 chk("clr idle ready", 64'(bus.req_ready), 64'(0));
        @(negedge clk);
        clr_req = 1'b0;
        #1 chk("clr ram_clr", 64'(ram_clr), 64'(1));
        chk("clr busy", 64'(clr_busy), 64'(1));
        chk("clr no ready", 64'(bus.req_ready), 64'(0));
        run_burst('{1'b0, 1'b0, 16'h0010, 8'd4, -1, 0, 8'h00, 8'd0, 5}, "post clr read");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_burst_arbiter.md
Name: ram_burst_arbiter

Overview:
- Sequences the shared 32K x 8 activation/weight RAM for two requesters: requester 0 (IO loader) and requester 1 (DCNN core).
- Accepts burst commands (read or write, base address, length) and grants them round-robin.
- Issues one RAM access per cycle and returns read data with a one-hot valid.
- Sits between the requesters and the RAM's address/data/read_signal/write_signal/RST pins.

Parameters:
- LEN_W, 8, burst length counter width; max burst is 2^LEN_W-1 bytes.
- ADDR_W, 16, RAM address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-low reset.
- req_valid  in  2  per-requester command valid; bit n = requester n.
- req_ready  out  2  one-hot command-accept pulse.
- req0_write, req1_write  in  1 each  1 = write burst, 0 = read burst.
- req0_base, req1_base  in  ADDR_W each  burst start address.
- req0_len, req1_len  in  LEN_W each  burst length in bytes; 0 is legal.
- req0_wdata, req1_wdata  in  8 each  write data.
- wdata_valid  in  2  per-requester write data valid.
- wdata_ready  out  2  one-hot; high while that requester owns an active write burst.
- rdata  out  8  read data, combinational pass-through of ram_dataout.
- rdata_valid  out  2  one-hot; rdata belongs to that requester this cycle.
- done  out  2  one-hot, one-cycle burst-complete pulse.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_read  out  1  RAM read_signal.
- ram_write  out  1  RAM write_signal.
- ram_dataout  in  8  RAM registered read data.

Behaviour:
- Reset (RST=0 at posedge): state IDLE, rr pointer set so requester 0 wins first, counters 0, rd_pend 0.
- All outputs are 0 during and after reset. A burst in flight is dropped with no done pulse. The RAM contents are not touched.
- States: IDLE, READ, WRITE, DONE. Internal regs: g (granted id), addr, remaining, rd_pend.
- IDLE arbitration:
  - One request valid: grant it.
  - Both valid: grant the one not granted last.
  - On grant: req_ready[g]=1 for that cycle; load addr=base and remaining=len.
  - Next state: DONE if len=0, else WRITE if write=1, else READ.
- READ:
  - Every cycle: ram_read=1, ram_addr=addr, addr+=1, remaining-=1, rd_pend<=1.
  - When remaining reaches 1, next state is DONE.
- rd_pend cleared in any cycle without ram_read. rdata_valid[g] = rd_pend, so read data arrives one cycle after its ram_read. There is no read backpressure.
- WRITE:
  - wdata_ready[g]=1. ram_write = wdata_valid[g], ram_addr=addr, ram_wdata=reqg_wdata (combinational mux).
  - A beat transfers when valid & ready; then addr+=1 and remaining-=1.
  - wdata_valid low is a stall: no write, addr holds, no timeout.
  - After the last beat, next state is DONE.
- DONE: done[g]=1 for exactly one cycle (rdata_valid also high for the final read byte); update rr pointer to g; go to IDLE.
- Minimum one IDLE cycle between bursts, so arbitration always happens in IDLE.
- Address arithmetic is modulo 2^ADDR_W: 16'hFFFF increments to 16'h0000. Bursts touching 0x8000 and above are the requester's responsibility; no range check.
- ram_read and ram_write are never high in the same cycle.
- Command inputs are sampled only on the req_ready cycle; later changes are ignored.
- Read burst of N accepted at T0: ram_read T1..TN, rdata_valid T2..TN+1, done TN+1.
- Write burst of N with data always valid: ram_write T1..TN, done TN+1.

Optional Feature:
- Macro: RAM_CLEAR_EN.
- Defined:
  - Adds input clr_req(1), output clr_busy(1) and output ram_clr(1) driving the RAM's active-high RST.
  - In IDLE, clr_req has priority over both requesters. Controller asserts ram_clr for one cycle, with clr_busy high that cycle and no req_ready. It then returns to IDLE.
  - rr pointer is unchanged by a clear.
- Undefined: ports absent; RAM RST tied low externally.

Test Plan:
- Reset then req0 write, base 0x0010, len 4, data 0xA1..0xA4 always valid -> ram_write T1..T4 at addr 0x0010..0x0013, done[0] at T5. Then req1 read same range -> rdata_valid[1] with 0xA1..0xA4 on T2..T5, done[1] T5.
- Both req_valid high in IDLE after reset -> requester 0 granted. Next contention -> requester 1. Alternation held over 6 bursts.
- Write burst len 3 with wdata_valid low 2 cycles mid-burst -> ram_write deasserted, addr held, done delayed 2 cycles, all 3 bytes correct.
- Read burst base 0xFFFE len 3 -> ram_addr 0xFFFE, 0xFFFF, 0x0000. len=0 command -> req_ready then done next cycle, no RAM access.
- RST low during READ at beat 2 of 5 -> next cycle all outputs 0, no done, state IDLE. New request is served normally.
- (RAM_CLEAR_EN) clr_req with req0 also pending -> ram_clr 1 cycle first, then req0 granted. Subsequent reads return 0x00.
